// File: rtl/status_register_file_mp_if.sv
// Bus bundle for status_register_file_mp: halt, write, flush and the packed per-channel read buses.
// Channel k occupies slice k of every packed read bus.
interface status_register_file_mp_if #(
  parameter int WORD_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 3,
  parameter int TAG_WIDTH    = 1,
  parameter int NUM_RD_PORTS = 2
) ();
  logic                               i_halt;
  logic                               o_freeze_inputs;
  logic                               i_wr_valid;
  logic [ADDR_WIDTH-1:0]              i_wr_addr;
  logic [WORD_WIDTH-1:0]              i_wr_data;
  logic                               i_flush;
  logic [NUM_RD_PORTS-1:0]            i_rd_valid;
  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr;
  logic [NUM_RD_PORTS*TAG_WIDTH-1:0]  i_rd_tag;
  logic [NUM_RD_PORTS-1:0]            o_rd_valid;
  logic [NUM_RD_PORTS*WORD_WIDTH-1:0] o_rd_data;
  logic [NUM_RD_PORTS-1:0]            o_rd_init;
  logic [NUM_RD_PORTS*TAG_WIDTH-1:0]  o_rd_tag;
  logic [ADDR_WIDTH:0]                o_init_count;

  modport master (
    output i_halt, i_wr_valid, i_wr_addr, i_wr_data, i_flush,
           i_rd_valid, i_rd_addr, i_rd_tag,
    input  o_freeze_inputs, o_rd_valid, o_rd_data, o_rd_init, o_rd_tag, o_init_count
  );

  modport slave (
    input  i_halt, i_wr_valid, i_wr_addr, i_wr_data, i_flush,
           i_rd_valid, i_rd_addr, i_rd_tag,
    output o_freeze_inputs, o_rd_valid, o_rd_data, o_rd_init, o_rd_tag, o_init_count
  );
endinterface

// File: rtl/status_register_file_mp.sv
// Multi-read-port status register file with per-word init bits, live init count, flush and halt.
// Optional macro STATUS_RF_WR_BYPASS_EN forwards same-cycle write data to matching read channels.
module status_register_file_mp #(
  parameter int WORD_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 3,
  parameter int TAG_WIDTH    = 1,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                   clk,
  input  logic                   arst_n,
  status_register_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_WIDTH-1:0]              r_mem [DEPTH];
  logic [DEPTH-1:0]                   r_init;
  logic [ADDR_WIDTH:0]                r_init_count;
  logic [NUM_RD_PORTS-1:0]            r_rd_valid;
  logic [NUM_RD_PORTS*WORD_WIDTH-1:0] r_rd_data;
  logic [NUM_RD_PORTS-1:0]            r_rd_init;
  logic [NUM_RD_PORTS*TAG_WIDTH-1:0]  r_rd_tag;

  logic                               w_wr_en;
  logic                               w_flush_en;
  logic [ADDR_WIDTH:0]                w_count_nxt;
  logic [NUM_RD_PORTS*WORD_WIDTH-1:0] w_rd_data_nxt;
  logic [NUM_RD_PORTS-1:0]            w_rd_init_nxt;
  logic [NUM_RD_PORTS*TAG_WIDTH-1:0]  w_rd_tag_nxt;

  assign w_wr_en    = bus.i_wr_valid & ~bus.i_halt;
  assign w_flush_en = bus.i_flush & ~bus.i_halt;

  always_comb begin
    w_rd_data_nxt = '0;
    w_rd_init_nxt = '0;
    w_rd_tag_nxt  = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      if (bus.i_rd_valid[k]) begin
        w_rd_data_nxt[k*WORD_WIDTH +: WORD_WIDTH] = r_mem[bus.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        w_rd_init_nxt[k] = r_init[bus.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        w_rd_tag_nxt[k*TAG_WIDTH +: TAG_WIDTH] = bus.i_rd_tag[k*TAG_WIDTH +: TAG_WIDTH];
`ifdef STATUS_RF_WR_BYPASS_EN
        // Forwarding overrides old init too, so a concurrent flush still reports init=1.
        if (w_wr_en && (bus.i_wr_addr == bus.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_rd_data_nxt[k*WORD_WIDTH +: WORD_WIDTH] = bus.i_wr_data;
          w_rd_init_nxt[k] = 1'b1;
        end
`else
        // Old-data semantics: the array and init bits are read before this cycle's write lands.
`endif
      end
    end
  end

  // Count tracks popcount(init) incrementally; it can only rise on a fresh word, so it never wraps.
  always_comb begin
    w_count_nxt = r_init_count;
    if (w_flush_en) begin
      w_count_nxt = {{ADDR_WIDTH{1'b0}}, w_wr_en};
    end else if (w_wr_en && !r_init[bus.i_wr_addr]) begin
      w_count_nxt = r_init_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_init       <= '0;
      r_init_count <= '0;
      r_rd_valid   <= '0;
      r_rd_data    <= '0;
      r_rd_init    <= '0;
      r_rd_tag     <= '0;
    end else if (!bus.i_halt) begin
      r_rd_valid   <= bus.i_rd_valid;
      r_rd_data    <= w_rd_data_nxt;
      r_rd_init    <= w_rd_init_nxt;
      r_rd_tag     <= w_rd_tag_nxt;
      r_init_count <= w_count_nxt;
      if (w_flush_en) begin
        r_init <= '0;
      end
      if (w_wr_en) begin
        r_init[bus.i_wr_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  assign bus.o_freeze_inputs = bus.i_halt;
  assign bus.o_rd_valid      = r_rd_valid;
  assign bus.o_rd_data       = r_rd_data;
  assign bus.o_rd_init       = r_rd_init;
  assign bus.o_rd_tag        = r_rd_tag;
  assign bus.o_init_count    = r_init_count;
endmodule

// File: tb/tb_status_register_file_mp.sv
// Bench for status_register_file_mp: directed vector table, async reset sequences, randomized run vs array model.
module tb_status_register_file_mp;
  localparam int WW = 12;
  localparam int AW = 3;
  localparam int TW = 1;
  localparam int NP = 2;
  localparam int DEPTH = 8;
`ifdef STATUS_RF_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        halt;
    logic        wv;
    logic [2:0]  wa;
    logic [11:0] wd;
    logic        fl;
    logic [1:0]  rv;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [1:0]  tg;
    logic [1:0]  ev;
    logic [11:0] ed0;
    logic [11:0] ed1;
    logic [1:0]  ei;
    logic [1:0]  et;
    logic [3:0]  ecnt;
    logic [1:0]  cd;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  status_register_file_mp_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .NUM_RD_PORTS(NP)) bus ();

  status_register_file_mp #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .NUM_RD_PORTS(NP)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain arrays, output registers and a popcount.
  logic [11:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_init  [DEPTH];
  logic [1:0]  m_v, m_i, m_t, m_dk;
  logic [11:0] m_d [2];
  int          m_cnt;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic halt, input logic wv, input logic [2:0] wa, input logic [11:0] wd,
                              input logic fl, input logic [1:0] rv, input logic [2:0] ra0, input logic [2:0] ra1,
                              input logic [1:0] tg, input logic [1:0] ev, input logic [11:0] ed0,
                              input logic [11:0] ed1, input logic [1:0] ei, input logic [1:0] et,
                              input logic [3:0] ecnt, input logic [1:0] cd);
    vec_t v;
    v.halt = halt; v.wv = wv; v.wa = wa; v.wd = wd; v.fl = fl; v.rv = rv; v.ra0 = ra0; v.ra1 = ra1;
    v.tg = tg; v.ev = ev; v.ed0 = ed0; v.ed1 = ed1; v.ei = ei; v.et = et; v.ecnt = ecnt; v.cd = cd;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_halt = 1'b0; bus.i_wr_valid = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_flush = 1'b0; bus.i_rd_valid = '0; bus.i_rd_addr = '0; bus.i_rd_tag = '0;
  endtask

  task automatic do_reset(input string nm);
    idle_inputs();
    arst_n = 1'b0;
    #1;
    check({nm, ".valid"}, 32'(bus.o_rd_valid), 32'd0);
    check({nm, ".data"},  32'(bus.o_rd_data),  32'd0);
    check({nm, ".init"},  32'(bus.o_rd_init),  32'd0);
    check({nm, ".tag"},   32'(bus.o_rd_tag),   32'd0);
    check({nm, ".count"}, 32'(bus.o_init_count), 32'd0);
    for (int a = 0; a < DEPTH; a++) m_init[a] = 1'b0;
    m_v = '0; m_i = '0; m_t = '0; m_dk = 2'b11; m_d[0] = '0; m_d[1] = '0; m_cnt = 0;
    #2;
    arst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input bit use_tbl, input string nm);
    logic [2:0] ra;
    bus.i_halt = v.halt; bus.i_wr_valid = v.wv; bus.i_wr_addr = v.wa; bus.i_wr_data = v.wd;
    bus.i_flush = v.fl; bus.i_rd_valid = v.rv; bus.i_rd_addr = {v.ra1, v.ra0}; bus.i_rd_tag = v.tg;
    if (!v.halt) begin
      for (int k = 0; k < 2; k++) begin
        ra = (k == 1) ? v.ra1 : v.ra0;
        if (v.rv[k]) begin
          m_v[k] = 1'b1;
          m_t[k] = v.tg[k];
          if (BYP && v.wv && (v.wa == ra)) begin
            m_d[k] = v.wd; m_i[k] = 1'b1; m_dk[k] = 1'b1;
          end else begin
            m_d[k] = m_mem[ra]; m_i[k] = m_init[ra]; m_dk[k] = m_known[ra];
          end
        end else begin
          m_v[k] = 1'b0; m_t[k] = 1'b0; m_d[k] = '0; m_i[k] = 1'b0; m_dk[k] = 1'b1;
        end
      end
      if (v.fl) for (int a = 0; a < DEPTH; a++) m_init[a] = 1'b0;
      if (v.wv) begin
        m_mem[v.wa] = v.wd; m_init[v.wa] = 1'b1; m_known[v.wa] = 1'b1;
      end
      m_cnt = 0;
      for (int a = 0; a < DEPTH; a++) m_cnt += int'(m_init[a]);
    end
    #1;
    check({nm, ".freeze"}, 32'(bus.o_freeze_inputs), 32'(v.halt));
    @(posedge clk);
    #1;
    check({nm, ".m.valid"}, 32'(bus.o_rd_valid), 32'(m_v));
    check({nm, ".m.init"},  32'(bus.o_rd_init),  32'(m_i));
    check({nm, ".m.tag"},   32'(bus.o_rd_tag),   32'(m_t));
    check({nm, ".m.count"}, 32'(bus.o_init_count), 32'(m_cnt));
    if (m_dk[0]) check({nm, ".m.data0"}, 32'(bus.o_rd_data[11:0]),  32'(m_d[0]));
    if (m_dk[1]) check({nm, ".m.data1"}, 32'(bus.o_rd_data[23:12]), 32'(m_d[1]));
    if (use_tbl) begin
      check({nm, ".t.valid"}, 32'(bus.o_rd_valid), 32'(v.ev));
      check({nm, ".t.init"},  32'(bus.o_rd_init),  32'(v.ei));
      check({nm, ".t.tag"},   32'(bus.o_rd_tag),   32'(v.et));
      check({nm, ".t.count"}, 32'(bus.o_init_count), 32'(v.ecnt));
      if (v.cd[0]) check({nm, ".t.data0"}, 32'(bus.o_rd_data[11:0]),  32'(v.ed0));
      if (v.cd[1]) check({nm, ".t.data1"}, 32'(bus.o_rd_data[23:12]), 32'(v.ed1));
    end
  endtask

  initial begin
    vec_t v;
    for (int a = 0; a < DEPTH; a++) begin
      m_mem[a] = '0; m_known[a] = 1'b0; m_init[a] = 1'b0;
    end

    // halt wv wa wd fl rv ra0 ra1 tg | ev ed0 ed1 ei et cnt cd
    for (int a = 0; a < DEPTH; a++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 3'(a), 3'(7 - a), 2'b00, 2'b11, 0, 0, 2'b00, 2'b00, 0, 2'b00));
    tbl.push_back(mk(0, 1, 3, 12'hABC, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b11));
    tbl.push_back(mk(0, 1, 5, 12'h123, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2, 2'b11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 3, 5, 2'b01, 2'b11, 12'hABC, 12'h123, 2'b11, 2'b01, 2, 2'b11));
    tbl.push_back(mk(0, 1, 3, 12'h777, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2, 2'b11));
    tbl.push_back(mk(0, 1, 6, 12'h055, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 3, 6, 2'b00, 2'b11, 12'h777, 12'h055, 2'b10, 2'b00, 1, 2'b11));
    // Halt: write/flush/reads ignored, outputs hold the previous read.
    tbl.push_back(mk(1, 1, 0, 12'hFFF, 0, 2'b11, 0, 0, 2'b11, 2'b11, 12'h777, 12'h055, 2'b10, 2'b00, 1, 2'b11));
    tbl.push_back(mk(1, 1, 0, 12'hFFF, 1, 2'b11, 0, 0, 2'b11, 2'b11, 12'h777, 12'h055, 2'b10, 2'b00, 1, 2'b11));
    tbl.push_back(mk(1, 1, 0, 12'hFFF, 0, 2'b11, 0, 0, 2'b11, 2'b11, 12'h777, 12'h055, 2'b10, 2'b00, 1, 2'b11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 6, 2'b00, 2'b11, 0, 12'h055, 2'b10, 2'b00, 1, 2'b10));
    tbl.push_back(mk(0, 1, 2, 12'h111, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2, 2'b11));
    tbl.push_back(mk(0, 1, 2, 12'h5A5, 0, 2'b10, 0, 2, 2'b10, 2'b10, 0, BYP ? 12'h5A5 : 12'h111,
                     2'b10, 2'b10, 2, 2'b11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2, 0, 2'b00, 2'b01, 12'h5A5, 0, 2'b01, 2'b00, 2, 2'b11));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b11));
    for (int a = 0; a < DEPTH; a++)
      tbl.push_back(mk(0, 1, 3'(a), 12'(12'h300 + a), 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00,
                       4'(a + 1), 2'b11));
    tbl.push_back(mk(0, 1, 0, 12'h999, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 8, 2'b11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 7, 2'b10, 2'b11, 12'h999, 12'h307, 2'b11, 2'b10, 8, 2'b11));

    do_reset("reset0");
    foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Async reset mid-cycle: outputs clear without a clock edge; data array survives.
    #2;
    do_reset("midreset");
    apply(mk(0, 0, 0, 0, 0, 2'b11, 7, 0, 2'b11, 2'b11, 12'h307, 12'h999, 2'b00, 2'b11, 0, 2'b11),
          1'b1, "postreset");

    // Flush + write + read of the written address in one cycle.
    apply(mk(0, 1, 4, 12'h4C4, 1, 2'b11, 4, 1, 2'b01, 2'b11, 12'h304, 12'h301,
             BYP ? 2'b01 : 2'b00, 2'b01, 1, BYP ? 2'b10 : 2'b11), 1'b0, "flushwr");

    for (int n = 0; n < 600; n++) begin
      v = mk(($urandom_range(7) == 0), $urandom_range(1), 3'($urandom_range(7)), 12'($urandom),
             ($urandom_range(15) == 0), 2'($urandom_range(3)), 3'($urandom_range(7)),
             3'($urandom_range(7)), 2'($urandom_range(3)), 0, 0, 0, 0, 0, 0, 0);
      apply(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
